// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: control/status bundle between the run controller and whoever drives it.
interface cpu_run_ctrl_if #(
    parameter int CYCLE_W = 16,
    parameter int PC_W = 32
);
    logic start, abort, step_mode, step;
    logic [PC_W-1:0] pc;
    logic cpu_reset, cpu_en, running, done, halted, timeout;
    logic [CYCLE_W-1:0] cycle_count;
    modport master (
        output start, abort, step_mode, step, pc,
        input cpu_reset, cpu_en, cycle_count, running, done, halted, timeout
    );
    modport slave (
        input start, abort, step_mode, step, pc,
        output cpu_reset, cpu_en, cycle_count, running, done, halted, timeout
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: core reset sequencing, clock-enable, cycle counting, free-run/single-step,
// and end-of-run detection on halt (pc stuck) or cycle budget.
module cpu_run_ctrl #(
    parameter int CYCLE_W = 16,
    parameter int MAX_CYCLES = 128,
    parameter int RESET_CYCLES = 4,
    parameter int PC_W = 32,
    parameter int HALT_REPEAT = 3
) (
    input logic clk,
    input logic reset,
    cpu_run_ctrl_if.slave bus
);
    localparam int RC_W = $clog2(RESET_CYCLES + 1);
    localparam int SC_W = $clog2(HALT_REPEAT);
    typedef enum logic [2:0] {IDLE, RST, RUN, STEP_WAIT, DONE} state_t;
    state_t state;
    logic [RC_W-1:0] rst_cnt;
    logic [SC_W-1:0] same_cnt, same_nx;
    logic [PC_W-1:0] last_pc;
    logic [CYCLE_W-1:0] cnt_nx;
    logic pc_valid, en, hit_halt, hit_to;
    always_comb begin
        en = state == RUN || (state == STEP_WAIT && bus.step && bus.step_mode);
        cnt_nx = &bus.cycle_count ? bus.cycle_count : bus.cycle_count + 1'b1;
        same_nx = (pc_valid && bus.pc == last_pc) ? same_cnt + 1'b1 : '0;
        hit_halt = same_nx == SC_W'(HALT_REPEAT - 1);
        hit_to = cnt_nx == CYCLE_W'(MAX_CYCLES);
    end
    assign bus.cpu_en = en;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            bus.cpu_reset <= 1'b1;
            bus.cycle_count <= '0;
            bus.running <= 1'b0;
            bus.done <= 1'b0;
            bus.halted <= 1'b0;
            bus.timeout <= 1'b0;
            rst_cnt <= '0;
            same_cnt <= '0;
            last_pc <= '0;
            pc_valid <= 1'b0;
        end else if (bus.abort) begin
            state <= IDLE;
            bus.cpu_reset <= 1'b1;
            bus.cycle_count <= '0;
            bus.running <= 1'b0;
            bus.done <= 1'b0;
            bus.halted <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) begin
                    state <= RST;
                    bus.cpu_reset <= 1'b1;
                    bus.done <= 1'b0;
                    bus.cycle_count <= '0;
                    bus.halted <= 1'b0;
                    bus.timeout <= 1'b0;
                    rst_cnt <= '0;
                    same_cnt <= '0;
                end
                RST: begin
                    rst_cnt <= rst_cnt + 1'b1;
                    if (rst_cnt == RC_W'(RESET_CYCLES - 1)) begin
                        state <= bus.step_mode ? STEP_WAIT : RUN;
                        bus.cpu_reset <= 1'b0;
                        bus.running <= 1'b1;
                        pc_valid <= 1'b0;
                    end
                end
                RUN, STEP_WAIT: begin
                    if (en) begin
                        bus.cycle_count <= cnt_nx;
                        same_cnt <= same_nx;
                        last_pc <= bus.pc;
                        pc_valid <= 1'b1;
                    end
                    // both end conditions on one cycle raise both flags in a single DONE entry
                    if (en && (hit_halt || hit_to)) begin
                        state <= DONE;
                        bus.running <= 1'b0;
                        bus.done <= 1'b1;
                        bus.halted <= hit_halt;
                        bus.timeout <= hit_to;
                    end else begin
                        state <= bus.step_mode ? STEP_WAIT : RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed run scenarios checked against a pc-history model every cycle,
// plus literal expectations at scenario boundaries.
module tb_cpu_run_ctrl;
    localparam int CYCLE_W = 16, MAX_CYCLES = 128, RESET_CYCLES = 4, PC_W = 32, HALT_REPEAT = 3;
    logic clk = 1'b0, reset = 1'b1;
    int tests = 0, fails = 0;
    cpu_run_ctrl_if #(.CYCLE_W(CYCLE_W), .PC_W(PC_W)) bus ();
    cpu_run_ctrl #(
        .CYCLE_W(CYCLE_W), .MAX_CYCLES(MAX_CYCLES), .RESET_CYCLES(RESET_CYCLES),
        .PC_W(PC_W), .HALT_REPEAT(HALT_REPEAT)
    ) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    logic [15:0] idx = '0, en_seen = '0;
    logic [PC_W-1:0] tab [0:15];
    bit tab_mode = 1'b0;
    assign bus.pc = tab_mode ? tab[idx[3:0]] : PC_W'(idx) << 2;
    always @(posedge clk) begin
        if (bus.start) begin
            idx <= '0;
            en_seen <= '0;
        end else if (bus.cpu_en) begin
            idx <= idx + 1'b1;
            en_seen <= en_seen + 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // model: phase 0 idle, 1 reset sequence, 2 core active, 3 finished
    int ph = 0, rst_left = 0;
    bit m_step = 1'b0, m_halt = 1'b0, m_to = 1'b0;
    logic [PC_W-1:0] hist [$];
    function automatic bit m_en();
        return ph == 2 && (!m_step || (bus.step && bus.step_mode));
    endfunction
    function automatic bit stuck();
        if (hist.size() < HALT_REPEAT) return 1'b0;
        for (int k = 1; k < HALT_REPEAT; k++)
            if (hist[hist.size() - 1 - k] != hist[hist.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset || bus.abort) begin
            ph = 0;
            hist.delete();
            m_halt = 1'b0;
            m_to = 1'b0;
        end else if ((ph == 0 || ph == 3) && bus.start) begin
            ph = 1;
            rst_left = RESET_CYCLES;
            hist.delete();
            m_halt = 1'b0;
            m_to = 1'b0;
        end else if (ph == 1) begin
            rst_left--;
            if (rst_left == 0) begin
                ph = 2;
                m_step = bus.step_mode;
            end
        end else if (ph == 2) begin
            if (m_en()) begin
                hist.push_back(bus.pc);
                m_halt = stuck();
                m_to = hist.size() == MAX_CYCLES;
                if (m_halt || m_to) ph = 3;
            end
            if (ph == 2) m_step = bus.step_mode;
        end
    end
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check("cpu_reset", bus.cpu_reset, ph <= 1);
            check("cpu_en", bus.cpu_en, m_en());
            check("cycle_count", bus.cycle_count, hist.size());
            check("running", bus.running, ph == 2);
            check("done", bus.done, ph == 3);
            check("halted", bus.halted, m_halt);
            check("timeout", bus.timeout, m_to);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start_run(output int n);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.cpu_reset && n < 20) begin
            n++;
            tick();
        end
    endtask
    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 300) begin
            n++;
            tick();
        end
        check("wait_done", bus.done, 1);
    endtask
    task automatic pulse_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.step_mode = 1'b0;
        bus.step = 1'b0;
        for (int i = 0; i < 16; i++) tab[i] = 32'(i) * 32'd100;
        tick();
        tick();
        check("rst_cpu_reset", bus.cpu_reset, 1);
        check("rst_cpu_en", bus.cpu_en, 0);
        check("rst_count", bus.cycle_count, 0);
        check("rst_flags", {bus.running, bus.done, bus.halted, bus.timeout}, 0);
        reset = 1'b0;
        tick();

        start_run(n);
        check("to_rst_len", n, RESET_CYCLES);
        wait_done();
        check("to_en_cycles", en_seen, 128);
        check("to_count", bus.cycle_count, 128);
        check("to_flags", {bus.done, bus.halted, bus.timeout}, 3'b101);

        tab[0] = 0; tab[1] = 4; tab[2] = 8; tab[3] = 12; tab[4] = 12; tab[5] = 12; tab[6] = 20;
        tab_mode = 1'b1;
        start_run(n);
        check("restart_timeout_clr", bus.timeout, 0);
        wait_done();
        check("halt_count", bus.cycle_count, 6);
        check("halt_flags", {bus.done, bus.halted, bus.timeout}, 3'b110);

        tab_mode = 1'b0;
        bus.step_mode = 1'b1;
        start_run(n);
        for (int i = 0; i < 5; i++) begin
            bus.step = 1'b1;
            tick();
            bus.step = 1'b0;
            tick();
            tick();
        end
        check("step_en_cycles", en_seen, 5);
        check("step_count", bus.cycle_count, 5);
        check("step_status", {bus.running, bus.done}, 2'b10);

        pulse_abort();
        check("abort_idle", {bus.cpu_reset, bus.running}, 2'b10);
        bus.step_mode = 1'b0;
        start_run(n);
        repeat (10) tick();
        check("sw_free10", bus.cycle_count, 10);
        bus.step_mode = 1'b1;
        repeat (20) tick();
        check("sw_hold", bus.cycle_count, 11);
        bus.step_mode = 1'b0;
        repeat (3) tick();
        check("sw_resume", bus.cycle_count, 13);

        pulse_abort();
        tab[0] = 0; tab[1] = 4; tab[2] = 8; tab[3] = 12; tab[4] = 16; tab[5] = 16; tab[6] = 16;
        tab_mode = 1'b1;
        start_run(n);
        repeat (6) tick();
        pulse_abort();
        check("abh_halted", bus.halted, 0);
        check("abh_count", bus.cycle_count, 0);
        check("abh_state", {bus.cpu_reset, bus.running, bus.done}, 3'b100);
        tab_mode = 1'b0;
        start_run(n);
        check("abh_rerun_rst", n, RESET_CYCLES);

        n = 0;
        while (bus.cycle_count != 50 && n < 100) begin
            n++;
            tick();
        end
        check("ar_reach50", bus.cycle_count, 50);
        reset = 1'b1;
        #1;
        check("ar_cpu_reset", bus.cpu_reset, 1);
        check("ar_cpu_en", bus.cpu_en, 0);
        check("ar_count", bus.cycle_count, 0);
        check("ar_flags", {bus.running, bus.done, bus.halted, bus.timeout}, 0);
        #2;
        reset = 1'b0;
        tick();
        tick();
        check("ar_idle", {bus.cpu_reset, bus.running}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
